// File: rtl/avalon_mm_pipe_bridge.sv
// Avalon-MM pipeline bridge: one registered command stage toward the host,
// outstanding-read throttling, and a registered read-response stage.
module avalon_mm_pipe_bridge #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MAX_PENDING = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    // agent side
    input  logic [ADDR_W-1:0]   s_address,
    input  logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_read,
    input  logic                s_write,
    input  logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W-1:0]   s_readdata,
    output logic                s_waitrequest,
    output logic                s_readdatavalid,
    // host side
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_waitrequest,
    input  logic                m_readdatavalid,
    output logic                protocol_err
);

    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    logic              cmd_valid;
    logic              cmd_is_read;
    logic              cmd_is_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [BE_W-1:0]   cmd_byteenable;
    logic [DATA_W-1:0] cmd_writedata;
    logic [PEND_W-1:0] pending;

    logic issue;
    logic accept;
    logic read_issue;
    logic pend_dec;
    logic rsp_drop;
    logic rsp_take;
    logic both_strobes;

    // Command handshake; s_waitrequest depends only on register state and m_waitrequest
    assign m_read        = cmd_valid & cmd_is_read & (pending < PEND_MAX);
    assign m_write       = cmd_valid & cmd_is_write;
    assign issue         = (m_read | m_write) & ~m_waitrequest;
    assign read_issue    = m_read & ~m_waitrequest;
    assign s_waitrequest = cmd_valid & ~issue;
    assign accept        = (s_read | s_write) & ~s_waitrequest;
    assign both_strobes  = accept & s_read & s_write;

    assign m_address     = cmd_address;
    assign m_byteenable  = cmd_byteenable;
    assign m_writedata   = cmd_writedata;

    // A response with nothing outstanding and nothing in the output stage is stray
    assign pend_dec = s_readdatavalid & (pending != '0);
    assign rsp_drop = m_readdatavalid & (pending == '0) & ~s_readdatavalid;
    assign rsp_take = m_readdatavalid & ~rsp_drop;

    // Command register: load on accept, retire on issue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid      <= 1'b0;
            cmd_is_read    <= 1'b0;
            cmd_is_write   <= 1'b0;
            cmd_address    <= '0;
            cmd_byteenable <= '0;
            cmd_writedata  <= '0;
        end else if (accept) begin
            cmd_valid      <= 1'b1;
            cmd_is_read    <= s_read & ~s_write;
            cmd_is_write   <= s_write;
            cmd_address    <= s_address;
            cmd_byteenable <= s_byteenable;
            cmd_writedata  <= s_writedata;
        end else if (issue) begin
            cmd_valid      <= 1'b0;
        end
    end

    // Outstanding-read counter, saturating at both ends
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            case ({read_issue, pend_dec})
                2'b10:   pending <= pending + PEND_W'(1);
                2'b01:   pending <= pending - PEND_W'(1);
                default: pending <= pending;
            endcase
        end
    end

    // Read-response stage; data holds while valid is low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_readdatavalid <= 1'b0;
            s_readdata      <= '0;
        end else begin
            s_readdatavalid <= rsp_take;
            if (rsp_take) begin
                s_readdata <= m_readdata;
            end
        end
    end

    // Sticky violation flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            protocol_err <= 1'b0;
        end else if (both_strobes | rsp_drop) begin
            protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_avalon_mm_pipe_bridge.sv
// Directed bench for avalon_mm_pipe_bridge: a per-cycle vector table plus
// hand sequences for read throttling and reset behaviour.
module tb_avalon_mm_pipe_bridge;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned MAXP   = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] s_address;
    logic [3:0]        s_byteenable;
    logic              s_read, s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [DATA_W-1:0] s_readdata;
    logic              s_waitrequest, s_readdatavalid;
    logic [ADDR_W-1:0] m_address;
    logic [3:0]        m_byteenable;
    logic              m_read, m_write;
    logic [DATA_W-1:0] m_writedata;
    logic [DATA_W-1:0] m_readdata;
    logic              m_waitrequest, m_readdatavalid;
    logic              protocol_err;

    avalon_mm_pipe_bridge #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_PENDING(MAXP)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s_address(s_address), .s_byteenable(s_byteenable),
        .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .s_readdatavalid(s_readdatavalid),
        .m_address(m_address), .m_byteenable(m_byteenable),
        .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
        .m_readdatavalid(m_readdatavalid), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle();
        s_address = '0; s_byteenable = '0; s_read = 1'b0; s_write = 1'b0;
        s_writedata = '0; m_readdata = '0; m_waitrequest = 1'b0; m_readdatavalid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " m_read"},  64'(m_read), 64'd0);
        chk({tag, " m_write"}, 64'(m_write), 64'd0);
        chk({tag, " s_wait"},  64'(s_waitrequest), 64'd0);
        chk({tag, " s_rdv"},   64'(s_readdatavalid), 64'd0);
        chk({tag, " s_rdata"}, 64'(s_readdata), 64'd0);
        chk({tag, " err"},     64'(protocol_err), 64'd0);
    endtask

    // Assert reset, check outputs immediately, release on a falling edge
    task automatic do_reset(input string tag);
        @(negedge clk);
        idle();
        reset_n = 1'b0;
        #1;
        chk_all_zero(tag);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        s_rd, s_wr;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        logic        m_wait, m_rdv;
        logic [31:0] m_rdata;
        logic        e_mr, e_mw, e_sw, e_rdv;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(
        input logic s_rd, input logic s_wr, input logic [31:0] addr, input logic [31:0] wdata,
        input logic [3:0] be, input logic m_wait, input logic m_rdv, input logic [31:0] m_rdata,
        input logic e_mr, input logic e_mw, input logic e_sw, input logic e_rdv,
        input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [3:0] e_be,
        input logic [31:0] e_rdata, input logic e_err);
        vec_t v;
        v.s_rd = s_rd; v.s_wr = s_wr; v.addr = addr; v.wdata = wdata; v.be = be;
        v.m_wait = m_wait; v.m_rdv = m_rdv; v.m_rdata = m_rdata;
        v.e_mr = e_mr; v.e_mw = e_mw; v.e_sw = e_sw; v.e_rdv = e_rdv;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_be = e_be;
        v.e_rdata = e_rdata; v.e_err = e_err;
        return v;
    endfunction

    localparam int NV = 19;
    vec_t vecs [NV];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // inputs --------------------------------------------  expected ---------------------------------------
        vecs[0]  = mk(0,1,32'h100,32'hDEADBEEF,4'hF,0,0,0,        0,0,0,0, 32'h0,  32'h0,        4'h0, 32'h0,        0);
        vecs[1]  = mk(0,0,0,0,0,0,0,0,                            0,1,0,0, 32'h100,32'hDEADBEEF, 4'hF, 32'h0,        0);
        vecs[2]  = mk(0,0,0,0,0,0,0,0,                            0,0,0,0, 32'h0,  32'h0,        4'h0, 32'h0,        0);
        vecs[3]  = mk(0,1,32'h200,32'h11111111,4'hF,0,0,0,        0,0,0,0, 32'h0,  32'h0,        4'h0, 32'h0,        0);
        vecs[4]  = mk(0,1,32'h204,32'h22222222,4'hF,0,0,0,        0,1,0,0, 32'h200,32'h11111111, 4'hF, 32'h0,        0);
        vecs[5]  = mk(0,1,32'h208,32'h33333333,4'hF,1,0,0,        0,1,1,0, 32'h204,32'h22222222, 4'hF, 32'h0,        0);
        vecs[6]  = mk(0,1,32'h208,32'h33333333,4'hF,1,0,0,        0,1,1,0, 32'h204,32'h22222222, 4'hF, 32'h0,        0);
        vecs[7]  = mk(0,1,32'h208,32'h33333333,4'hF,1,0,0,        0,1,1,0, 32'h204,32'h22222222, 4'hF, 32'h0,        0);
        vecs[8]  = mk(0,1,32'h208,32'h33333333,4'hF,0,0,0,        0,1,0,0, 32'h204,32'h22222222, 4'hF, 32'h0,        0);
        vecs[9]  = mk(0,0,0,0,0,0,0,0,                            0,1,0,0, 32'h208,32'h33333333, 4'hF, 32'h0,        0);
        vecs[10] = mk(0,0,0,0,0,0,0,0,                            0,0,0,0, 32'h0,  32'h0,        4'h0, 32'h0,        0);
        vecs[11] = mk(1,0,32'h300,32'h0,4'hC,0,0,0,               0,0,0,0, 32'h0,  32'h0,        4'h0, 32'h0,        0);
        vecs[12] = mk(0,0,0,0,0,0,0,0,                            1,0,0,0, 32'h300,32'h0,        4'hC, 32'h0,        0);
        vecs[13] = mk(0,0,0,0,0,0,1,32'h12345678,                 0,0,0,0, 32'h0,  32'h0,        4'h0, 32'h0,        0);
        vecs[14] = mk(0,0,0,0,0,0,0,0,                            0,0,0,1, 32'h0,  32'h0,        4'h0, 32'h12345678, 0);
        vecs[15] = mk(0,0,0,0,0,0,0,0,                            0,0,0,0, 32'h0,  32'h0,        4'h0, 32'h12345678, 0);
        vecs[16] = mk(1,1,32'h400,32'hCAFEF00D,4'h3,0,0,0,        0,0,0,0, 32'h0,  32'h0,        4'h0, 32'h12345678, 0);
        vecs[17] = mk(0,0,0,0,0,0,0,0,                            0,1,0,0, 32'h400,32'hCAFEF00D, 4'h3, 32'h12345678, 1);
        vecs[18] = mk(0,0,0,0,0,0,0,0,                            0,0,0,0, 32'h0,  32'h0,        4'h0, 32'h12345678, 1);

        idle();
        reset_n = 1'b0;
        do_reset("reset0");

        // Table: inputs at the falling edge, outputs sampled 1 time unit later
        for (int i = 0; i < NV; i++) begin
            s_read = vecs[i].s_rd; s_write = vecs[i].s_wr; s_address = vecs[i].addr;
            s_writedata = vecs[i].wdata; s_byteenable = vecs[i].be;
            m_waitrequest = vecs[i].m_wait; m_readdatavalid = vecs[i].m_rdv;
            m_readdata = vecs[i].m_rdata;
            #1;
            chk($sformatf("v%0d m_read", i),  64'(m_read), 64'(vecs[i].e_mr));
            chk($sformatf("v%0d m_write", i), 64'(m_write), 64'(vecs[i].e_mw));
            chk($sformatf("v%0d s_wait", i),  64'(s_waitrequest), 64'(vecs[i].e_sw));
            chk($sformatf("v%0d s_rdv", i),   64'(s_readdatavalid), 64'(vecs[i].e_rdv));
            chk($sformatf("v%0d s_rdata", i), 64'(s_readdata), 64'(vecs[i].e_rdata));
            chk($sformatf("v%0d err", i),     64'(protocol_err), 64'(vecs[i].e_err));
            if (vecs[i].e_mr || vecs[i].e_mw) begin
                chk($sformatf("v%0d m_addr", i), 64'(m_address), 64'(vecs[i].e_addr));
                chk($sformatf("v%0d m_be", i),   64'(m_byteenable), 64'(vecs[i].e_be));
            end
            if (vecs[i].e_mw)
                chk($sformatf("v%0d m_wdata", i), 64'(m_writedata), 64'(vecs[i].e_wdata));
            @(negedge clk);
        end

        // Six streamed reads against a limit of four, one response at cycle 8
        do_reset("reset1");
        begin
            int ri;
            logic e_sw, e_mr, e_rdv;
            logic [31:0] e_addr, e_rdata;
            ri = 0;
            e_rdata = 32'h0;
            for (int c = 0; c < 12; c++) begin
                idle();
                s_read = (c <= 10);
                s_address = 32'h1000 + 32'(4 * ri);
                s_byteenable = 4'hF;
                if (c == 8) begin
                    m_readdatavalid = 1'b1;
                    m_readdata = 32'hA5A50001;
                end
                e_sw   = (c >= 5 && c <= 9) || (c == 11);
                e_mr   = (c >= 1 && c <= 4) || (c == 10);
                e_addr = (c == 10) ? 32'h1010 : 32'h1000 + 32'(4 * (c - 1));
                e_rdv  = (c == 9);
                if (c == 9) e_rdata = 32'hA5A50001;
                #1;
                chk($sformatf("rd%0d s_wait", c), 64'(s_waitrequest), 64'(e_sw));
                chk($sformatf("rd%0d m_read", c), 64'(m_read), 64'(e_mr));
                chk($sformatf("rd%0d s_rdv", c),  64'(s_readdatavalid), 64'(e_rdv));
                chk($sformatf("rd%0d s_rdata", c), 64'(s_readdata), 64'(e_rdata));
                if (e_mr) chk($sformatf("rd%0d m_addr", c), 64'(m_address), 64'(e_addr));
                if (s_read && !e_sw) ri++;
                @(negedge clk);
            end
        end

        // Reset with four reads outstanding and a read buffered
        do_reset("reset2");
        begin
            idle();
            m_readdatavalid = 1'b1;
            m_readdata = 32'h00000055;
            #1;
            chk("late err_before", 64'(protocol_err), 64'd0);
            @(negedge clk);
            idle();
            s_write = 1'b1; s_address = 32'h500; s_writedata = 32'h77; s_byteenable = 4'hF;
            #1;
            chk("late s_rdv", 64'(s_readdatavalid), 64'd0);
            chk("late err", 64'(protocol_err), 64'd1);
            @(negedge clk);
            idle();
            #1;
            chk("post m_write", 64'(m_write), 64'd1);
            chk("post m_addr", 64'(m_address), 64'h500);
            chk("post s_rdv", 64'(s_readdatavalid), 64'd0);
            chk("post s_rdata", 64'(s_readdata), 64'd0);
            @(negedge clk);
            idle();
            s_read = 1'b1; s_address = 32'h600; s_byteenable = 4'hF;
            #1;
            chk("post2 m_write", 64'(m_write), 64'd0);
            @(negedge clk);
            idle();
            #1;
            chk("post3 m_read", 64'(m_read), 64'd1);
            chk("post3 m_addr", 64'(m_address), 64'h600);
            chk("post3 err", 64'(protocol_err), 64'd1);
            @(negedge clk);
            @(negedge clk);
            #1;
            chk("sticky err", 64'(protocol_err), 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/avalon_mm_pipe_bridge.md
AVALON_MM_PIPE_BRIDGE -- requirements
Module: avalon_mm_pipe_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data bus width in bits; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have parameter MAX_PENDING, default 4, meaning maximum number of outstanding reads (1..15).
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 s_address  in  ADDR_W  agent-side command address.
REQ-007 s_byteenable  in  DATA_W/8  agent-side byte lanes.
REQ-008 s_read / s_write  in  1 each  agent-side command strobes.
REQ-009 s_writedata  in  DATA_W  agent-side write data.
REQ-010 s_readdata  out  DATA_W  agent-side read data.
REQ-011 s_waitrequest  out  1  stalls the agent-side command.
REQ-012 s_readdatavalid  out  1  qualifies s_readdata.
REQ-013 m_address, m_byteenable, m_read, m_write, m_writedata  out  ADDR_W, DATA_W/8, 1, 1, DATA_W  host-side command.
REQ-014 m_readdata  in  DATA_W, and m_waitrequest, m_readdatavalid  in  1 each  host-side response.
REQ-015 protocol_err  out  1  sticky protocol-violation flag.

Function
REQ-016 SHALL hold one command register: cmd_valid, address, byteenable, is_read, is_write and writedata.
REQ-017 SHALL define m_read = cmd_valid & is_read & (pending < MAX_PENDING), and m_write = cmd_valid & is_write; the m_ command fields are driven from the register.
REQ-018 SHALL define issue = (m_read | m_write) & ~m_waitrequest.
REQ-019 SHALL drive s_waitrequest = cmd_valid & ~issue; this is combinational and carries no dependency on s_read or s_write.
REQ-020 SHALL define accept = (s_read | s_write) & ~s_waitrequest; on accept the register loads the s_ fields and cmd_valid becomes 1.
REQ-021 Issue without accept SHALL clear cmd_valid; issue together with accept SHALL reload the register back-to-back, giving 1 command per cycle throughput.
REQ-022 Command latency SHALL be exactly 1 cycle: a command accepted at edge N is presented on m_ from edge N onward (cycle N+1).
REQ-023 If s_read and s_write are both high at accept, the command SHALL be treated as a write, and protocol_err SHALL be set.
REQ-024 pending SHALL be a counter of clog2(MAX_PENDING+1) bits: +1 on a read issue, -1 on an s_readdatavalid cycle, net 0 when both occur; it SHALL never exceed MAX_PENDING or wrap below 0.
REQ-025 While pending == MAX_PENDING, a read in the register SHALL hold m_read low and s_waitrequest high; writes SHALL be unaffected.
REQ-026 Read response: s_readdatavalid and s_readdata SHALL be registered copies of m_readdatavalid and m_readdata, with exactly 1 cycle of latency, in order, with no buffering beyond that stage.
REQ-027 If m_readdatavalid arrives while pending == 0 and no response is in the output stage, the response SHALL be dropped (s_readdatavalid stays 0) and protocol_err SHALL be set.
REQ-028 s_readdata SHALL hold its last value while s_readdatavalid is 0.
REQ-029 protocol_err SHALL clear only on reset.

Reset
REQ-030 On reset_n low, the block SHALL asynchronously clear cmd_valid, pending, s_readdatavalid, s_readdata and protocol_err to 0; consequently m_read, m_write and s_waitrequest are 0.
REQ-031 Reset mid-operation SHALL discard the buffered command and the pending count; responses that arrive later SHALL be treated per REQ-027.
REQ-032 After reset_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-033 Scenario: write at 0x100, data 0xDEADBEEF, byteenable 0xF, m_waitrequest=0 -> m_write=1 with the same fields for exactly 1 cycle, starting 1 cycle later.
REQ-034 Scenario: 6 back-to-back reads, MAX_PENDING=4, no responses -> 4 m_read issues, then s_waitrequest=1; one response -> 5th read issues 1 cycle after s_readdatavalid.
REQ-035 Scenario: m_waitrequest held high 3 cycles with a write in the register -> s_waitrequest=1 for those 3 cycles, the command is stable, and no duplicate is issued.
REQ-036 Scenario: m_readdatavalid with m_readdata=0x12345678 -> s_readdatavalid=1 and s_readdata=0x12345678 on the next cycle; pending decrements.
REQ-037 Scenario: m_readdatavalid while pending=0 -> no s_readdatavalid, and protocol_err=1 until reset.
REQ-038 Scenario: reset_n pulsed low with 2 reads pending and a command buffered -> all outputs 0 immediately, pending=0, and a late response sets protocol_err.
